// File: rtl/serial_adder.sv
// Bit-serial adder: loads two WIDTH-bit operands on start, adds them LSB-first
// one bit per clock through a single registered carry, then reports the sum,
// unsigned carry-out and signed overflow with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);

    // Counter holds 0..WIDTH so it never wraps inside an operation
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;

    // One full-adder slice on the current LSBs and the stored carry
    always_comb begin
        sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
        carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        last_bit  = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state, datapath shifting and result capture
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    c_d     = cin_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry_nxt;
                acc_d = {sum_bit, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    s_d     = {sum_bit, acc_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    // c_q is the carry entering the MSB on this final step
                    ovf_d   = c_q ^ carry_nxt;
                    state_d = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_FIN);
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign s_o    = s_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, ignored start,
// mid-run reset and a back-to-back random run against an arithmetic model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int n_cmp;
    int n_err;

    serial_adder #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .a_i    (a),
        .b_i    (b),
        .cin_i  (cin),
        .busy_o (busy),
        .done_o (done),
        .s_o    (s),
        .cout_o (cout),
        .ovf_o  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, signed overflow from operand/result signs
    task automatic check_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                                input logic ec);
        int unsigned total;
        logic [W-1:0] es;
        logic         eo;
        total = int'(ea) + int'(eb) + int'(ec);
        es    = W'(total);
        eo    = (ea[W-1] == eb[W-1]) && (es[W-1] != ea[W-1]);
        check({tag, "_s"},    32'(s),    32'(es));
        check({tag, "_cout"}, 32'(total >> W), 32'(cout));
        check({tag, "_ovf"},  32'(ovf),  32'(eo));
    endtask

    // Wait (bounded) for done after an accepted start; checks busy/done timing
    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        check({tag, "_busy_first"}, 32'(busy), 32'd1);
        while (!done && cyc < 3 * W) begin
            @(posedge clk); #1;
            cyc++;
            check({tag, "_excl"}, 32'(busy & done), 32'd0);
        end
        check({tag, "_latency"}, 32'(cyc), 32'(W));
    endtask

    // Start an operation; leaves start high when hold is set
    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input bit hold);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        wait_done(tag);
        check_result(tag, va, vb, vc);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W-1:0] held_s;
        int           extra_done;

        n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s",    32'(s),    32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases
        run_op("d_3c0f", 8'h3C, 8'h0F, 1'b0, 1'b0);
        check("d_3c0f_s_const", 32'(s), 32'h4B);
        run_op("d_ff01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("d_7f01", 8'h7F, 8'h01, 1'b0, 1'b0);
        check("d_7f01_ovf_const", 32'(ovf), 32'd1);
        run_op("d_8080", 8'h80, 8'h80, 1'b1, 1'b0);
        run_op("d_0001", 8'h00, 8'h00, 1'b1, 1'b0);

        // Result held through idle
        held_s = s;
        repeat (3) begin @(posedge clk); #1; end
        check("hold_s", 32'(s), 32'(held_s));
        check("hold_done_low", 32'(done), 32'd0);

        // Start during run is ignored; exactly one done follows
        a = 8'h55; b = 8'h2A; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 8'hF0; b = 8'hF0; cin = 1'b0; start = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b0;
        extra_done = 0;
        while (!done && extra_done < 3 * W) begin @(posedge clk); #1; extra_done++; end
        check("ign_done_seen", 32'(done), 32'd1);
        check_result("ign", 8'h55, 8'h2A, 1'b1);
        extra_done = 0;
        repeat (12) begin @(posedge clk); #1; if (done) extra_done++; end
        check("ign_single_done", 32'(extra_done), 32'd0);

        // Asynchronous reset during the fourth run cycle
        a = 8'hC3; b = 8'h99; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_s",    32'(s),    32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        check("arst_ovf",  32'(ovf),  32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(busy | done), 32'd0);
        run_op("post_rst", 8'hC3, 8'h99, 1'b1, 1'b0);

        // Back-to-back random operations with start held high
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run_op("rnd", ra, rb, rc, 1'b1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("rnd_end_idle", 32'(busy | done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
